command_fifo_reader: RTL

- Read-side controller for the command FIFO. It turns the FIFO's blind `rinc`/`rdata` interface, which has 1-cycle read latency and no empty flag, into a valid/ready command stream for downstream compute units.
- It mirrors FIFO occupancy from the accepted-write strobe and issues pops only when data exists.
- It absorbs read latency in a 2-entry output skid queue, so throughput is 1 cmd/cycle under continuous ready.
- It flushes in lockstep with the FIFO on `replay_iter_flag`.

---
 rtl/command_fifo_reader_pkg.sv | 21 ++
 rtl/cmd_skid_queue.sv | 75 +++++++
 rtl/command_fifo_reader.sv | 87 ++++++++
 3 files changed

// File: rtl/command_fifo_reader_pkg.sv
// Shared definitions for the command FIFO and its consumers:
// packet type, FIFO size macro and read latency.
`ifndef COM_FIFO_SIZE
`define COM_FIFO_SIZE 8
`endif

package command_fifo_reader_pkg;

    // Cycles from rinc to valid rdata at the FIFO output.
    localparam int RD_LAT = 1;

    // Queue must cover the read latency plus one drained entry
    // to sustain one command per cycle.
    localparam int SKID_DEPTH = RD_LAT + 1;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [11:0] operand;
    } com_packet;

endpackage

// File: rtl/cmd_skid_queue.sv
// Two-entry valid/ready queue of com_packet with synchronous flush.
// Ports: clk_i, rst_i (async high), flush_i, push_i/data_i (tail
// write), pop_i (head accept), valid_o/data_o (head), occ_o (0..2).
module cmd_skid_queue
    import command_fifo_reader_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       flush_i,
    input  logic       push_i,
    input  com_packet  data_i,
    input  logic       pop_i,
    output logic       valid_o,
    output com_packet  data_o,
    output logic [1:0] occ_o
);

    com_packet  head_q, head_d;
    com_packet  tail_q, tail_d;
    logic [1:0] occ_q, occ_d;
    logic       do_pop;

    assign do_pop  = pop_i & (occ_q != 2'd0);
    assign valid_o = (occ_q != 2'd0);
    assign data_o  = valid_o ? head_q : '0;
    assign occ_o   = occ_q;

    // Empty slots are kept at zero so the head never shows
    // stale data once drained.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = 2'd0;
        end else begin
            unique case ({push_i, do_pop})
                2'b10: begin
                    if (occ_q == 2'd0) head_d = data_i;
                    else               tail_d = data_i;
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    head_d = tail_q;
                    tail_d = '0;
                    occ_d  = occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_d = data_i;
                    end else begin
                        head_d = tail_q;
                        tail_d = data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

endmodule

// File: rtl/command_fifo_reader.sv
// Read-side controller turning the blind rinc/rdata FIFO port into a
// valid/ready command stream. Mirrors FIFO occupancy from
// push_accepted, pops only when data exists, absorbs the read latency
// in a skid queue and flushes with the FIFO on replay_iter_flag.
// Ports: clk, reset (async high), replay_iter_flag, push_accepted,
// rinc/rdata (FIFO read), cmd_valid/cmd_ready/cmd_data (stream),
// fifo_count/fifo_empty (mirrored occupancy).
module command_fifo_reader
    import command_fifo_reader_pkg::*;
#(
    parameter int DEPTH = `COM_FIFO_SIZE,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             replay_iter_flag,
    input  logic             push_accepted,
    output logic             rinc,
    input  com_packet        rdata,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output com_packet        cmd_data,
    output logic [CNT_W-1:0] fifo_count,
    output logic             fifo_empty
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             inflight_q, inflight_d;
    logic [1:0]       q_occ;
    logic             drain;
    logic [2:0]       pending;

    assign drain   = cmd_valid & cmd_ready;
    assign pending = {1'b0, q_occ} + {2'b00, inflight_q};

    // pending - drain < SKID_DEPTH, rearranged to avoid underflow.
    assign rinc = ~replay_iter_flag
                & (count_q != '0)
                & (pending < (3'(SKID_DEPTH) + {2'b00, drain}));

    always_comb begin
        count_d    = count_q;
        inflight_d = rinc;
        if (replay_iter_flag) begin
            count_d = '0;
        end else if (push_accepted && !rinc) begin
            // Saturate: a push at full count is an upstream error.
            if (count_q != CNT_W'(DEPTH))
                count_d = count_q + CNT_W'(1);
        end else if (!push_accepted && rinc) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            inflight_q <= inflight_d;
        end
    end

    always @(posedge clk) begin
        if (!reset && !replay_iter_flag)
            assert (!(push_accepted && !rinc
                      && count_q == CNT_W'(DEPTH)));
    end

    // rdata is only meaningful the cycle after a pop.
    cmd_skid_queue u_queue (
        .clk_i   (clk),
        .rst_i   (reset),
        .flush_i (replay_iter_flag),
        .push_i  (inflight_q),
        .data_i  (rdata),
        .pop_i   (drain),
        .valid_o (cmd_valid),
        .data_o  (cmd_data),
        .occ_o   (q_occ)
    );

    assign fifo_count = count_q;
    assign fifo_empty = (count_q == '0);

endmodule
